// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: d = a - b - bin, DIGIT bits per cycle, LSB digit first.
// Define SERIAL_SUBTRACTOR_SAT_EN to clamp a borrowing result to zero.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic [1:0]       fsm_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = $clog2(STEPS) + 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: DIGIT must divide WIDTH and both must be >= 1");
    end
  endgenerate

  // Handshake: a transfer happens on a clk edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             valid_r;
  logic             bout_r;

  logic [DIGIT:0]   sub;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] d_next;
  logic [WIDTH-1:0] d_final;

  // Operands shift right each step; result digits enter at the top so the
  // last step leaves digit 0 at the LSB.
  always_comb begin
    sub     = {1'b0, a_r[DIGIT-1:0]} - {1'b0, b_r[DIGIT-1:0]} - (DIGIT+1)'(borrow);
    diff_w  = WIDTH'(sub[DIGIT-1:0]);
    d_next  = (d_r >> DIGIT) | (diff_w << (WIDTH - DIGIT));
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    d_final = sub[DIGIT] ? '0 : d_next;
`else
    d_final = d_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      d_r     <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      valid_r <= 1'b0;
      bout_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
            d_r    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_r    <= a_r >> DIGIT;
          b_r    <= b_r >> DIGIT;
          borrow <= sub[DIGIT];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) begin
            d_r     <= d_final;
            bout_r  <= sub[DIGIT];
            valid_r <= 1'b1;
            state   <= DONE;
          end else begin
            d_r <= d_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = valid_r;
  assign d         = d_r;
  assign b_out     = bout_r;
  assign fsm_state = state;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; WIDTH SHALL be at least 1.
REQ-002 Parameter DIGIT, default 1, sets the bits processed per cycle; DIGIT SHALL divide WIDTH exactly, and an illegal combination SHALL fail elaboration.
REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: operands a, b and bin are valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 Port a, input, WIDTH bits: minuend, unsigned.
REQ-008 Port b, input, WIDTH bits: subtrahend, unsigned.
REQ-009 Port bin, input, 1 bit: borrow-in, subtracted at the LSB.
REQ-010 Port out_valid, output, 1 bit: d and b_out hold a completed result.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port d, output, WIDTH bits: difference.
REQ-013 Port b_out, output, 1 bit: final borrow, meaning a < b + bin.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, decoded combinationally from the state.
REQ-016 In IDLE, when in_valid=1 at a clk edge, the block SHALL capture a, b and bin, clear the step counter, clear the d register and enter RUN.
REQ-017 In RUN, each cycle SHALL process DIGIT bits, LSB digit first.
- Digit i of d SHALL be (a_digit - b_digit - borrow) mod 2^DIGIT.
- The borrow register SHALL take the digit borrow-out.
- The step counter SHALL increment.
REQ-018 The borrow register SHALL be initialised to bin on capture.
REQ-019 After the step that processes the MSB digit, the FSM SHALL enter DONE.
- Capture at edge k gives out_valid=1 after edge k+WIDTH/DIGIT.
- Latency is WIDTH/DIGIT cycles.
REQ-020 In DONE, out_valid SHALL be 1, and d and b_out SHALL stay stable until out_ready=1 at a clk edge.
REQ-021 On that edge the FSM SHALL return to IDLE, and out_valid SHALL fall.
REQ-022 There is no same-cycle turnaround: a new operation SHALL be accepted no earlier than the cycle after the result is consumed.
REQ-023 in_valid and operand changes SHALL be ignored in RUN and DONE.
REQ-024 out_valid SHALL be 0 in IDLE and RUN; while out_valid=0, the d and b_out values have no meaning.
REQ-025 The step counter width SHALL be clog2(WIDTH/DIGIT)+1, and the counter SHALL never wrap during an operation.
REQ-026 With WIDTH=DIGIT, one step, the block SHALL behave as a registered single-step subtractor; with WIDTH=1 it computes the half/full subtractor truth table.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for clk, force:
- state to IDLE;
- out_valid to 0, d to 0 and b_out to 0;
- the counter, borrow register and operand registers to 0.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation, and no result SHALL be presented afterwards.
REQ-029 After rst deasserts, in_ready SHALL be 1 and the first edge SHALL be able to accept an operation.

Configuration
REQ-030 Macro SERIAL_SUBTRACTOR_SAT_EN SHALL select saturating mode.
- Defined: on entry to DONE, if b_out=1 then d SHALL be forced to all zeros; b_out is still reported as 1.
- Undefined: d SHALL be the wrap-around result, (a - b - bin) mod 2^WIDTH.
- Latency SHALL be identical in both builds.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> d=0x02, b_out=0, out_valid exactly 8 cycles after capture.
REQ-032 WIDTH=8, DIGIT=4: a=0x03, b=0x05, bin=0 -> b_out=1 after 2 cycles.
- Without SAT_EN: d=0xFE.
- With SAT_EN: d=0x00.
REQ-033 WIDTH=8, DIGIT=2: a=0x00, b=0x00, bin=1 -> d=0xFF (0x00 under SAT_EN), b_out=1; a=0xFF, b=0xFF, bin=0 -> d=0x00, b_out=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> d, b_out and out_valid stay unchanged and in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-035 Reset mid-RUN: assert rst asynchronously at step 3 of 8 -> outputs read 0 before the next clk edge, and the next operation (0x10-0x01) returns d=0x0F, b_out=0 with no stale result.
REQ-036 WIDTH=1, DIGIT=1, bin=0: sweep (a,b) = (0,0), (0,1), (1,0), (1,1) -> (d, b_out) = (0,0), (1,1), (1,0), (0,0); with SAT_EN the (0,1) case gives d=0.
